// File: rtl/vram_pkg.sv
// Shared widths and types for the VRAM arbiter: arbitration states and the
// requester tags that travel with a read until its data returns.
package vram_pkg;
  localparam int VRAM_ADDR_WIDTH_DEF = 18;
  localparam int VRAM_DATA_WIDTH_DEF = 2;
  localparam int MAX_LOCK_DEF        = 8;

  typedef enum logic [1:0] {ARB, LOCKED, COOLDOWN} arb_state_t;
  typedef enum logic [1:0] {REQ_DISP, REQ_PHYS, REQ_DRAW} requester_t;

  typedef struct packed {
    logic       valid;
    requester_t tag;
  } rd_tag_t;
endpackage

// File: rtl/vram_arbiter_if.sv
// Requester and VRAM signal bundle for vram_arbiter. The slave modport is the
// arbiter's view; the master modport is the requesters' and memory's view.
interface vram_arbiter_if
  import vram_pkg::*;
#(
  parameter int VRAM_ADDR_WIDTH = VRAM_ADDR_WIDTH_DEF,
  parameter int VRAM_DATA_WIDTH = VRAM_DATA_WIDTH_DEF
) ();
  logic                       disp_req_i;
  logic [VRAM_ADDR_WIDTH-1:0] disp_addr_i;
  logic                       disp_gnt_o;
  logic                       disp_rvalid_o;
  logic [VRAM_DATA_WIDTH-1:0] disp_rdata_o;

  logic                       phys_req_i;
  logic                       phys_we_i;
  logic                       phys_lock_i;
  logic [VRAM_ADDR_WIDTH-1:0] phys_addr_i;
  logic [VRAM_DATA_WIDTH-1:0] phys_wdata_i;
  logic                       phys_gnt_o;
  logic                       phys_rvalid_o;
  logic [VRAM_DATA_WIDTH-1:0] phys_rdata_o;

  logic                       draw_req_i;
  logic [VRAM_ADDR_WIDTH-1:0] draw_addr_i;
  logic [VRAM_DATA_WIDTH-1:0] draw_wdata_i;
  logic                       draw_gnt_o;

  logic [VRAM_ADDR_WIDTH-1:0] vram_addr_o;
  logic                       vram_we_o;
  logic [VRAM_DATA_WIDTH-1:0] vram_wdata_o;
  logic [VRAM_DATA_WIDTH-1:0] vram_rdata_i;

  modport slave (
    input  disp_req_i, disp_addr_i,
    output disp_gnt_o, disp_rvalid_o, disp_rdata_o,
    input  phys_req_i, phys_we_i, phys_lock_i, phys_addr_i, phys_wdata_i,
    output phys_gnt_o, phys_rvalid_o, phys_rdata_o,
    input  draw_req_i, draw_addr_i, draw_wdata_i,
    output draw_gnt_o,
    output vram_addr_o, vram_we_o, vram_wdata_o,
    input  vram_rdata_i
  );

  modport master (
    output disp_req_i, disp_addr_i,
    input  disp_gnt_o, disp_rvalid_o, disp_rdata_o,
    output phys_req_i, phys_we_i, phys_lock_i, phys_addr_i, phys_wdata_i,
    input  phys_gnt_o, phys_rvalid_o, phys_rdata_o,
    output draw_req_i, draw_addr_i, draw_wdata_i,
    input  draw_gnt_o,
    input  vram_addr_o, vram_we_o, vram_wdata_o,
    output vram_rdata_i
  );
endinterface

// File: rtl/vram_rd_tag_pipe.sv
// Two-stage tag pipe matching the VRAM read latency: a read issued in cycle N
// raises its requester's rvalid in cycle N+2.
module vram_rd_tag_pipe
  import vram_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       issue_valid,
  input  requester_t issue_tag,
  output logic       disp_rvalid,
  output logic       phys_rvalid
);
  rd_tag_t stage_addr;
  rd_tag_t stage_data;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      stage_addr <= '0;
      stage_data <= '0;
    end else begin
      stage_addr <= '{valid: issue_valid, tag: issue_tag};
      stage_data <= stage_addr;
    end
  end

  assign disp_rvalid = stage_data.valid && (stage_data.tag == REQ_DISP);
  assign phys_rvalid = stage_data.valid && (stage_data.tag == REQ_PHYS);
endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display first, then round-robin physics/draw with
// a bounded physics lock for atomic read-modify-write.
//   state    | meaning
//   ARB      | round-robin between physics and draw
//   LOCKED   | physics holds the bus against draw, lock_cnt counts held cycles
//   COOLDOWN | one cycle after a forced release, draw favoured over physics
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int VRAM_ADDR_WIDTH = VRAM_ADDR_WIDTH_DEF,
  parameter int VRAM_DATA_WIDTH = VRAM_DATA_WIDTH_DEF,
  parameter int MAX_LOCK        = MAX_LOCK_DEF
) (
  input logic           clk_i,
  input logic           reset_i,
  vram_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  arb_state_t                 state;
  logic                       rr_draw;
  logic [CNT_W-1:0]           lock_cnt;
  logic [VRAM_ADDR_WIDTH-1:0] vram_addr_q;
  logic                       vram_we_q;
  logic [VRAM_DATA_WIDTH-1:0] vram_wdata_q;

  logic       disp_gnt;
  logic       phys_gnt;
  logic       draw_gnt;
  logic       rd_issue;
  requester_t rd_tag;
  logic       disp_rvalid;
  logic       phys_rvalid;

  always_comb begin
    disp_gnt = 1'b0;
    phys_gnt = 1'b0;
    draw_gnt = 1'b0;
    if (bus.disp_req_i) begin
      disp_gnt = 1'b1;
    end else begin
      case (state)
        LOCKED: phys_gnt = bus.phys_req_i;
        COOLDOWN: begin
          draw_gnt = bus.draw_req_i;
          phys_gnt = bus.phys_req_i && !bus.draw_req_i;
        end
        default: begin
          if (bus.phys_req_i && bus.draw_req_i) begin
            phys_gnt = !rr_draw;
            draw_gnt = rr_draw;
          end else begin
            phys_gnt = bus.phys_req_i;
            draw_gnt = bus.draw_req_i;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state        <= ARB;
      rr_draw      <= 1'b0;
      lock_cnt     <= '0;
      vram_addr_q  <= '0;
      vram_we_q    <= 1'b0;
      vram_wdata_q <= '0;
    end else begin
      vram_we_q <= 1'b0;
      if (disp_gnt) begin
        vram_addr_q  <= bus.disp_addr_i;
        vram_wdata_q <= '0;
      end else if (phys_gnt) begin
        vram_addr_q  <= bus.phys_addr_i;
        vram_we_q    <= bus.phys_we_i;
        vram_wdata_q <= bus.phys_wdata_i;
      end else if (draw_gnt) begin
        vram_addr_q  <= bus.draw_addr_i;
        vram_we_q    <= 1'b1;
        vram_wdata_q <= bus.draw_wdata_i;
      end

      if (phys_gnt) begin
        rr_draw <= 1'b1;
      end else if (draw_gnt) begin
        rr_draw <= 1'b0;
      end

      case (state)
        ARB: begin
          if (phys_gnt && bus.phys_lock_i) begin
            state    <= LOCKED;
            lock_cnt <= CNT_W'(1);
          end
        end
        LOCKED: begin
          // A voluntary drop wins over reaching the limit in the same cycle.
          if (!bus.phys_lock_i) begin
            state    <= ARB;
            lock_cnt <= '0;
          end else if (lock_cnt >= CNT_W'(MAX_LOCK - 1)) begin
            state    <= COOLDOWN;
            lock_cnt <= lock_cnt + CNT_W'(1);
          end else begin
            lock_cnt <= lock_cnt + CNT_W'(1);
          end
        end
        COOLDOWN: begin
          state    <= ARB;
          lock_cnt <= '0;
        end
        default: begin
          state    <= ARB;
          lock_cnt <= '0;
        end
      endcase
    end
  end

  assign rd_issue = disp_gnt || (phys_gnt && !bus.phys_we_i);
  assign rd_tag   = disp_gnt ? REQ_DISP : REQ_PHYS;

  vram_rd_tag_pipe u_rd_tag_pipe (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .issue_valid (rd_issue),
    .issue_tag   (rd_tag),
    .disp_rvalid (disp_rvalid),
    .phys_rvalid (phys_rvalid)
  );

  // Grants are combinational from the requests, so hold them low during reset.
  assign bus.disp_gnt_o    = disp_gnt && reset_i;
  assign bus.phys_gnt_o    = phys_gnt && reset_i;
  assign bus.draw_gnt_o    = draw_gnt && reset_i;
  assign bus.disp_rvalid_o = disp_rvalid;
  assign bus.phys_rvalid_o = phys_rvalid;
  assign bus.disp_rdata_o  = disp_rvalid ? bus.vram_rdata_i : '0;
  assign bus.phys_rdata_o  = phys_rvalid ? bus.vram_rdata_i : '0;
  assign bus.vram_addr_o   = vram_addr_q;
  assign bus.vram_we_o     = vram_we_q;
  assign bus.vram_wdata_o  = vram_wdata_q;
endmodule
